sitcp_tx_packer: RTL and testbench



---
 rtl/sitcp_tx_packer_pkg.sv | 23 ++
 rtl/sitcp_tx_packer_if.sv | 23 ++
 rtl/sitcp_tx_packer_rr_arbiter.sv | 43 ++++
 rtl/sitcp_tx_packer.sv | 103 ++++++++++
 tb/tb_sitcp_tx_packer.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sitcp_tx_packer_pkg.sv
// Shared types and helpers for the SiTCP TX packer: FSM encoding, header tag
// default, channel-index width and frame length.
package sitcp_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_SEQ  = 2'd2,
      ST_PAY  = 2'd3
   } state_t;

   localparam logic [3:0] HDR_TAG_DEF = 4'hA;

   // A single channel still needs a 1-bit index register.
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int frame_len(input int data_w);
      return 2 + data_w / 8;
   endfunction

endpackage

// File: rtl/sitcp_tx_packer_if.sv
// Channel-side valid/ready bundle plus the SiTCP TCP TX byte port.
// The slave modport is the packer's view; master is the sources/SiTCP side.
interface sitcp_tx_packer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32
);
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_ready;
   logic                     tx_full;
   logic                     tx_wr;
   logic [7:0]               tx_data;

   modport master (
      output ch_valid, ch_data, tx_full,
      input  ch_ready, tx_wr, tx_data
   );

   modport slave (
      input  ch_valid, ch_data, tx_full,
      output ch_ready, tx_wr, tx_data
   );
endinterface

// File: rtl/sitcp_tx_packer_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the channel
// after the last accepted one; pointer moves only when the grant is taken.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] i_req,
   input  logic              i_adv,
   output logic [NUM_CH-1:0] o_gnt,
   output logic [CH_W-1:0]   o_gnt_idx,
   output logic              o_any
);

   logic [CH_W-1:0] r_last;
   int              w_c;

   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      o_any     = 1'b0;
      w_c       = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_c = (int'(r_last) + k) % NUM_CH;
         if (!o_any && i_req[w_c]) begin
            o_any      = 1'b1;
            o_gnt[w_c] = 1'b1;
            o_gnt_idx  = CH_W'(w_c);
         end
      end
   end

   // Reset to the last channel so channel 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= CH_W'(NUM_CH - 1);
      end else if (i_adv) begin
         r_last <= o_gnt_idx;
      end
   end

endmodule

// File: rtl/sitcp_tx_packer.sv
// Round-robin multi-channel word packer into SiTCP TX bytes; grant in t, header on tx_wr in t+2.
// tx_full stalls the byte stream in place (tx_wr low, state/byte held); no grant while full.
module sitcp_tx_packer
   import sitcp_tx_pkg::*;
#(
   parameter int         NUM_CH  = 4,
   parameter int         DATA_W  = 32,
   parameter logic [3:0] HDR_TAG = HDR_TAG_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_enable,
   sitcp_tx_packer_if.slave     bus,
   output logic                 o_busy,
   output logic [7:0]           o_seq_num,
   output logic [15:0]          o_pkt_cnt
);

   localparam int CH_W = ch_w(NUM_CH);
   localparam int NB   = DATA_W / 8;

   state_t            r_state;
   logic [DATA_W-1:0] r_sh;
   logic [CH_W-1:0]   r_ch;
   logic [3:0]        r_bcnt;
   logic              r_tx_wr;
   logic [7:0]        r_tx_data;
   logic [7:0]        r_seq;
   logic [15:0]       r_pkt;

   logic [NUM_CH-1:0] w_gnt;
   logic [CH_W-1:0]   w_gnt_idx;
   logic              w_any;
   logic              w_take;

   assign w_take       = !rst && i_enable && (r_state == ST_IDLE) && w_any && !bus.tx_full;
   assign bus.ch_ready = w_take ? w_gnt : '0;
   assign bus.tx_wr    = r_tx_wr;
   assign bus.tx_data  = r_tx_data;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_seq_num    = r_seq;
   assign o_pkt_cnt    = r_pkt;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_req     (bus.ch_valid),
      .i_adv     (w_take),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx),
      .o_any     (w_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_sh      <= '0;
         r_ch      <= '0;
         r_bcnt    <= '0;
         r_tx_wr   <= 1'b0;
         r_tx_data <= '0;
         r_seq     <= '0;
         r_pkt     <= '0;
      end else if (r_state == ST_IDLE) begin
         r_tx_wr <= 1'b0;
         if (w_take) begin
            r_sh    <= bus.ch_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
            r_ch    <= w_gnt_idx;
            r_bcnt  <= '0;
            r_state <= ST_HDR;
         end
      end else if (bus.tx_full) begin
         r_tx_wr <= 1'b0;
      end else begin
         r_tx_wr <= 1'b1;
         case (r_state)
            ST_HDR: begin
               r_tx_data <= {HDR_TAG, 4'(r_ch)};
               r_state   <= ST_SEQ;
            end
            ST_SEQ: begin
               r_tx_data <= r_seq;
               r_state   <= ST_PAY;
            end
            ST_PAY: begin
               r_tx_data <= r_sh[DATA_W-1 -: 8];
               r_sh      <= r_sh << 8;
               r_bcnt    <= r_bcnt + 4'd1;
               if (r_bcnt == 4'(NB - 1)) begin
                  r_seq   <= r_seq + 8'd1;
                  r_pkt   <= r_pkt + 16'd1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sitcp_tx_packer.sv
// Scoreboard bench for sitcp_tx_packer: expected bytes are queued when a grant is
// seen and compared as tx_wr bytes appear; per-scenario tasks check timing and counters.
module tb_sitcp_tx_packer;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        busy;
   logic [7:0]  seq_num;
   logic [15:0] pkt_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0]        exp_q[$];
   logic [7:0]        wr_dat[$];
   int                gnt_log[$];
   int                rdy_cyc[$];
   int                wr_cyc[$];
   logic [7:0]        m_seq = 8'h00;
   logic [DATA_W-1:0] mon_w;
   logic [7:0]        mon_e;

   sitcp_tx_packer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus();

   sitcp_tx_packer #(
      .NUM_CH  (NUM_CH),
      .DATA_W  (DATA_W),
      .HDR_TAG (4'hA)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_enable  (enable),
      .bus       (bus),
      .o_busy    (busy),
      .o_seq_num (seq_num),
      .o_pkt_cnt (pkt_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push a full expected frame on each grant, pop on each written byte.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         exp_q.delete();
         m_seq = 8'h00;
      end else begin
         if (bus.ch_ready != '0) begin
            checks++;
            if ($countones(bus.ch_ready) != 1) begin
               errors++;
               $display("FAIL ready_onehot: got %b, required one-hot", bus.ch_ready);
            end
            for (int g = 0; g < NUM_CH; g++) begin
               if (bus.ch_ready[g]) begin
                  mon_w = bus.ch_data[g*DATA_W +: DATA_W];
                  exp_q.push_back({4'hA, 4'(g)});
                  exp_q.push_back(m_seq);
                  for (int b = DATA_W/8 - 1; b >= 0; b--) exp_q.push_back(mon_w[b*8 +: 8]);
                  m_seq = m_seq + 8'd1;
                  gnt_log.push_back(g);
                  rdy_cyc.push_back(cyc);
               end
            end
         end
         if (bus.tx_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_byte: got %02h, no byte expected", bus.tx_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus.tx_data !== mon_e) begin
                  errors++;
                  $display("FAIL sb_byte: got %02h, required %02h", bus.tx_data, mon_e);
               end
            end
            wr_dat.push_back(bus.tx_data);
            wr_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout: busy=%0b pending=%0d after %0d cycles, required drained", name, busy, exp_q.size(), budget);
      end
   endtask

   task automatic wait_grants(input int base, input int want, input int budget, input string name);
      int n = 0;
      while ((gnt_log.size() - base) < want && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_grant_timeout: got %0d grants, required %0d", name, gnt_log.size() - base, want);
      end
   endtask

   task automatic reset_dut();
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      enable = 1'b1;
      bus.ch_valid = '1;
      bus.ch_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (bus.ch_ready !== 4'b0000) begin errors++; $display("FAIL reset_ch_ready: got %b, required 0000", bus.ch_ready); end
      checks++;
      if (bus.tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr: got %b, required 0", bus.tx_wr); end
      checks++;
      if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %02h, required 00", bus.tx_data); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++;
      if (seq_num !== 8'h00 || pkt_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL reset_counters: got seq=%02h pkt=%04h, required 00/0000", seq_num, pkt_cnt);
      end
      tick();
      rst = 1'b0;
      bus.ch_valid = '0;
   endtask

   task automatic test_single();
      logic [7:0] ref_b[6] = '{8'hA0, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      int g0 = gnt_log.size();
      int w0 = wr_cyc.size();
      int bad = 0;
      tick();
      bus.ch_data[31:0] = 32'h11223344;
      bus.ch_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (bus.ch_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b, required 0001", bus.ch_ready); end
      tick();
      bus.ch_valid = '0;
      wait_drain(30, "single");
      checks++;
      if (wr_cyc.size() - w0 != 6 || gnt_log.size() - g0 != 1) begin
         errors++;
         $display("FAIL single_count: got %0d bytes/%0d grants, required 6/1", wr_cyc.size() - w0, gnt_log.size() - g0);
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (wr_cyc[w0+i] != rdy_cyc[g0] + 2 + i) bad++;
            if (wr_dat[w0+i] !== ref_b[i]) bad++;
         end
         checks++;
         if (bad != 0) begin errors++; $display("FAIL single_stream: got %0d byte/timing deviations, required 0", bad); end
      end
      checks++;
      if (seq_num !== 8'h01 || pkt_cnt !== 16'd1) begin
         errors++;
         $display("FAIL single_counters: got seq=%02h pkt=%0d, required 01/1", seq_num, pkt_cnt);
      end
   endtask

   task automatic test_round_robin();
      int g0 = gnt_log.size();
      tick();
      for (int i = 0; i < NUM_CH; i++) bus.ch_data[i*DATA_W +: DATA_W] = {16'hC0DE, 16'(i)};
      bus.ch_valid = 4'b1111;
      wait_grants(g0, 5, 80, "rr");
      tick();
      bus.ch_valid = '0;
      wait_drain(40, "rr");
      if (gnt_log.size() - g0 >= 5) begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (gnt_log[g0+i] != i % NUM_CH) begin
               errors++;
               $display("FAIL rr_order[%0d]: got ch%0d, required ch%0d", i, gnt_log[g0+i], i % NUM_CH);
            end
         end
         for (int i = 1; i < 5; i++) begin
            checks++;
            if (rdy_cyc[g0+i] - rdy_cyc[g0+i-1] != 7) begin
               errors++;
               $display("FAIL rr_spacing[%0d]: got %0d cycles, required 7", i, rdy_cyc[g0+i] - rdy_cyc[g0+i-1]);
            end
         end
      end
      checks++;
      if (seq_num !== 8'h05 || pkt_cnt !== 16'd5) begin
         errors++;
         $display("FAIL rr_counters: got seq=%02h pkt=%0d, required 05/5", seq_num, pkt_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ref_b[6] = '{8'hA0, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
      int gap_ref[5] = '{1, 1, 1, 4, 1};
      int w0 = wr_cyc.size();
      int bad = 0;
      tick();
      bus.ch_data[31:0] = 32'h11223344;
      bus.ch_valid = 4'b0001;
      tick();
      bus.ch_valid = '0;
      repeat (4) tick();
      bus.tx_full = 1'b1;
      repeat (3) tick();
      bus.tx_full = 1'b0;
      wait_drain(30, "bp");
      checks++;
      if (wr_cyc.size() - w0 != 6) begin
         errors++;
         $display("FAIL bp_count: got %0d bytes, required 6", wr_cyc.size() - w0);
      end else begin
         for (int i = 0; i < 6; i++) if (wr_dat[w0+i] !== ref_b[i]) bad++;
         for (int i = 0; i < 5; i++) if (wr_cyc[w0+i+1] - wr_cyc[w0+i] != gap_ref[i]) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL bp_stream: got %0d byte/gap deviations, required 0", bad); end
      end
   endtask

   task automatic test_enable_drop();
      int g0 = gnt_log.size();
      int w0 = wr_cyc.size();
      int bad = 0;
      tick();
      bus.ch_data[63:32] = 32'hDEADBEEF;
      bus.ch_valid = 4'b0010;
      tick();
      tick();
      enable = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (bus.ch_ready !== 4'b0000) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL en_ready_after_drop: got %0d pulses, required 0", bad); end
      checks++;
      if (gnt_log.size() - g0 != 1 || wr_cyc.size() - w0 != 6) begin
         errors++;
         $display("FAIL en_frame: got %0d grants/%0d bytes, required 1/6", gnt_log.size() - g0, wr_cyc.size() - w0);
      end
      checks++;
      if (busy !== 1'b0 || pkt_cnt !== 16'd7) begin
         errors++;
         $display("FAIL en_idle: got busy=%b pkt=%0d, required 0/7", busy, pkt_cnt);
      end
      bus.ch_valid = '0;
      enable = 1'b1;
   endtask

   task automatic test_reset_abort();
      int w0;
      tick();
      bus.ch_data[31:0] = 32'h55667788;
      bus.ch_valid = 4'b0001;
      tick();
      bus.ch_valid = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (bus.tx_wr !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: got tx_wr=%b busy=%b, required 0/0", bus.tx_wr, busy);
      end
      tick();
      rst = 1'b0;
      w0 = wr_cyc.size();
      tick();
      checks++;
      if (pkt_cnt !== 16'd0 || seq_num !== 8'h00) begin
         errors++;
         $display("FAIL abort_counters: got pkt=%0d seq=%02h, required 0/00", pkt_cnt, seq_num);
      end
      bus.ch_valid = 4'b0001;
      tick();
      bus.ch_valid = '0;
      wait_drain(30, "abort");
      checks++;
      if (wr_cyc.size() - w0 != 6) begin
         errors++;
         $display("FAIL abort_count: got %0d bytes, required 6", wr_cyc.size() - w0);
      end else begin
         checks++;
         if (wr_dat[w0] !== 8'hA0 || wr_dat[w0+1] !== 8'h00 || wr_dat[w0+2] !== 8'h55) begin
            errors++;
            $display("FAIL abort_next_frame: got %02h %02h %02h, required A0 00 55", wr_dat[w0], wr_dat[w0+1], wr_dat[w0+2]);
         end
      end
   endtask

   task automatic test_wrap();
      int g0;
      int w0;
      reset_dut();
      g0 = gnt_log.size();
      w0 = wr_cyc.size();
      bus.ch_data[95:64] = 32'hCAFE0002;
      bus.ch_valid = 4'b0100;
      wait_grants(g0, 257, 257*7 + 40, "wrap");
      tick();
      bus.ch_valid = '0;
      wait_drain(40, "wrap");
      checks++;
      if (pkt_cnt !== 16'd257 || seq_num !== 8'h01) begin
         errors++;
         $display("FAIL wrap_counters: got pkt=%0d seq=%02h, required 257/01", pkt_cnt, seq_num);
      end
      checks++;
      if (wr_cyc.size() - w0 != 257*6) begin
         errors++;
         $display("FAIL wrap_count: got %0d bytes, required %0d", wr_cyc.size() - w0, 257*6);
      end else begin
         checks++;
         if (wr_dat[w0+255*6+1] !== 8'hFF || wr_dat[w0+256*6+1] !== 8'h00 || wr_dat[w0+256*6] !== 8'hA2) begin
            errors++;
            $display("FAIL wrap_seq: got f256 seq=%02h f257 hdr=%02h seq=%02h, required FF A2 00",
                     wr_dat[w0+255*6+1], wr_dat[w0+256*6], wr_dat[w0+256*6+1]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      bus.ch_valid = '0;
      bus.ch_data = '0;
      bus.tx_full = 1'b0;
      test_reset();
      test_single();
      reset_dut();
      test_round_robin();
      test_backpressure();
      test_enable_drop();
      test_reset_abort();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
